// File: rtl/rtc_seg_display.sv
// Six-digit multiplexed seven-segment driver showing BCD time as HH.MM.SS.
// Time is latched once per scan frame; the decimal points toggle when the seconds value moves.

module rtc_seg_digit (
    input  logic [3:0] bcd,
    input  logic       dp_on,
    output logic [7:0] seg
);
    logic [6:0] body;

    // Active-low {g..a}; anything outside 0-9 renders as a dash.
    always_comb begin
        body = 7'h3F;
        case (bcd)
            4'd0:    body = 7'h40;
            4'd1:    body = 7'h79;
            4'd2:    body = 7'h24;
            4'd3:    body = 7'h30;
            4'd4:    body = 7'h19;
            4'd5:    body = 7'h12;
            4'd6:    body = 7'h02;
            4'd7:    body = 7'h78;
            4'd8:    body = 7'h00;
            4'd9:    body = 7'h10;
            default: body = 7'h3F;
        endcase
    end

    assign seg = {~dp_on, body};
endmodule

module rtc_seg_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Time_hour,
    input  logic [7:0] Time_munite,
    input  logic [7:0] Time_second,
    output logic [7:0] SMG_Data,
    output logic [5:0] Scan_Sig
);
    localparam int NUM_DIGITS = 6;
    localparam int CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       snap_h, snap_m, snap_s;
    logic             dp_flag;

    logic                             slot_end;
    logic                             frame_end;
    logic                             blank;
    logic [NUM_DIGITS-1:0][3:0]       digit;
    logic [NUM_DIGITS-1:0][7:0]       seg_all;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd5);
    assign blank     = (cnt < BLANK_LIM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Snapshot at the frame boundary so a frame never mixes old and new time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            snap_h  <= 8'h00;
            snap_m  <= 8'h00;
            snap_s  <= 8'h00;
            dp_flag <= 1'b0;
        end else if (frame_end) begin
            snap_h  <= Time_hour;
            snap_m  <= Time_munite;
            snap_s  <= Time_second;
            if (Time_second != snap_s)
                dp_flag <= ~dp_flag;
        end
    end

    // Digit 0 (leftmost) is hour tens, digit 5 is second units.
    assign digit = {snap_s[3:0], snap_s[7:4],
                    snap_m[3:0], snap_m[7:4],
                    snap_h[3:0], snap_h[7:4]};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        localparam bit DP_POS = (g == 1) || (g == 3);
        rtc_seg_digit u_dig (
            .bcd   (digit[g]),
            .dp_on (dp_flag && DP_POS),
            .seg   (seg_all[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST || blank) begin
            SMG_Data <= 8'hFF;
            Scan_Sig <= '1;
        end else begin
            SMG_Data <= seg_all[idx];
            Scan_Sig <= ~(NUM_DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_rtc_seg_display.sv
// Scoreboard bench for rtc_seg_display with SCAN_DIV=8, BLANK_CYC=2.
// Stimulus queues expected digit slots; a monitor reassembles slots from the outputs and checks them.

module tb_rtc_seg_display;
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] Time_hour, Time_munite, Time_second;
    logic [7:0] SMG_Data;
    logic [5:0] Scan_Sig;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] scan;
        logic [7:0] seg;
        int         len;
    } slot_t;

    slot_t exp_q[$];

    logic       mon_en = 1'b0;
    logic       in_slot = 1'b0;
    logic [5:0] cur_scan;
    logic [7:0] cur_seg;
    int         cur_len;
    logic       stable;

    rtc_seg_display #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Time_hour   (Time_hour),
        .Time_munite (Time_munite),
        .Time_second (Time_second),
        .SMG_Data    (SMG_Data),
        .Scan_Sig    (Scan_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got seg=%h scan=%h, want seg=%h scan=%h",
                     name, got[13:6], got[5:0], exp[13:6], exp[5:0]);
        end
    endtask

    task automatic push_slot(input logic [5:0] scan, input logic [7:0] seg, input int len);
        slot_t s;
        s.scan = scan;
        s.seg  = seg;
        s.len  = len;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5);
        push_slot(6'h3E, d0, 6);
        push_slot(6'h3D, d1, 6);
        push_slot(6'h3B, d2, 6);
        push_slot(6'h37, d3, 6);
        push_slot(6'h2F, d4, 6);
        push_slot(6'h1F, d5, 6);
    endtask

    // Monitor: a slot is the run of non-blank cycles between blanking gaps.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (Scan_Sig != 6'h3F) begin
                if (!in_slot) begin
                    in_slot  = 1'b1;
                    cur_scan = Scan_Sig;
                    cur_seg  = SMG_Data;
                    cur_len  = 1;
                    stable   = 1'b1;
                end else begin
                    cur_len++;
                    if (Scan_Sig != cur_scan || SMG_Data != cur_seg) stable = 1'b0;
                end
            end else begin
                checks++;
                if (SMG_Data !== 8'hFF) begin
                    failures++;
                    $display("FAIL blank_seg: got seg=%h during blanking, want FF", SMG_Data);
                end
                if (in_slot) begin
                    slot_t e;
                    in_slot = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL slot_unexpected: got scan=%h seg=%h len=%0d, want none",
                                 cur_scan, cur_seg, cur_len);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur_scan !== e.scan || cur_seg !== e.seg || cur_len != e.len || !stable) begin
                            failures++;
                            $display("FAIL slot: got scan=%h seg=%h len=%0d stable=%0d, want scan=%h seg=%h len=%0d stable=1",
                                     cur_scan, cur_seg, cur_len, stable, e.scan, e.seg, e.len);
                        end
                    end
                end
            end
        end
    end

    initial begin
        RST         = 1'b1;
        Time_hour   = 8'h12;
        Time_munite = 8'h22;
        Time_second = 8'h22;

        // Frame 0 shows the reset snapshot; later frames follow the input schedule below.
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        push_frame(8'hF9, 8'h24, 8'hA4, 8'h24, 8'hA4, 8'hA4);
        push_frame(8'hC0, 8'h10, 8'hA4, 8'h24, 8'hA4, 8'hA4);
        push_frame(8'hC0, 8'h90, 8'hA4, 8'hA4, 8'hA4, 8'hB0);
        push_frame(8'hC0, 8'h90, 8'hA4, 8'hA4, 8'hA4, 8'hB0);
        push_frame(8'hC0, 8'h10, 8'hA4, 8'h24, 8'hB0, 8'hBF);
        push_slot(6'h3E, 8'hC0, 6);
        push_slot(6'h3D, 8'h10, 6);
        push_slot(6'h3B, 8'hA4, 6);
        push_slot(6'h37, 8'h24, 6);
        push_slot(6'h2F, 8'hB0, 3);
        push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("reset_hold", {SMG_Data, Scan_Sig}, {8'hFF, 6'h3F});
        end
        RST    = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);
        chk("reset_release", {SMG_Data, Scan_Sig}, {8'hFF, 6'h3F});

        // Hour change while frame 1 is on digit 2: must not show until frame 2.
        repeat (65) @(negedge CLK);
        Time_hour = 8'h09;
        repeat (35) @(negedge CLK);
        Time_second = 8'h23;
        repeat (100) @(negedge CLK);
        Time_second = 8'h3A;

        // Reset sampled while digit 4 is on screen at cnt 5.
        repeat (124) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("reset_mid", {SMG_Data, Scan_Sig}, {8'hFF, 6'h3F});
        RST = 1'b0;

        repeat (50) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL slots_left: got %0d unconsumed slots, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
